color_track_multi: RTL
======================

// Module: color_track_multi
// PURPOSE
//  N-channel successor of the single-colour detector: per-pixel temporal-history filtering for N_CH colours at once, plus per-frame count and bounding box per channel.
//  Sits between the median-filter/history-RAM read port and the tracking logic; writes updated history back to the RAM.
//  Latches per-channel results at each VGA_VS falling edge and flags them with a one-cycle frame_valid pulse.
// PARAMETERS
//  N_CH       3   number of colour channels
//  HIST_D     4   history bits per channel (2..8); shift depth
//  THR_W      3   threshold width per channel; must hold 0..HIST_D
//  CNT_W      19  per-channel pixel-count width (saturating)
//  MIN_COUNT  16  minimum frame count for the channel's found flag
// PORTS
//  clk            in   1               system clock
//  reset          in   1               asynchronous, active-low reset
//  VGA_VS         in   1               VGA vertical sync; falling edge = frame boundary
//  pix_valid      in   1               pixel inputs valid this cycle
//  read_x         in   10              pixel x; counted only if < SCREEN_W
//  read_y         in   10              pixel y; counted only if < SCREEN_H
//  read_addr      in   19              history-RAM address of this pixel
//  median_color   in   N_CH            median-filtered per-channel colour match
//  color_history  in   N_CH*HIST_D     stored history, channel c at [c*HIST_D +: HIST_D]
//  threshold      in   N_CH*THR_W      per-channel popcount threshold (strict >)
//  color_detected out  N_CH            registered per-pixel detect
//  updated_color_history out N_CH*HIST_D  history to write back
//  we             out  1               history-RAM write enable
//  write_addr     out  19              history-RAM write address
//  frame_valid    out  1               one-cycle pulse: frame results updated
//  found          out  N_CH            count >= MIN_COUNT for the last frame
//  color_count    out  N_CH*CNT_W      per-channel count, last frame
//  x_min, x_max   out  N_CH*10         per-channel bounding box, last frame
//  y_min, y_max   out  N_CH*10         per-channel bounding box, last frame
// BEHAVIOUR
//  Reset (reset=0, async): every output 0; accumulators cleared (min=SCREEN-1, max=0, count=0); vs_prev=0; armed=0.
//  Pixel path, 1-cycle latency, registered:
//   - det[c] = pix_valid & median_color[c] & (popcount(hist[c]) > threshold[c]); threshold >= HIST_D never detects.
//   - updated_color_history[c] = {hist[c][HIST_D-2:0], median_color[c]}; raw median is shifted in, not det.
//   - we = pix_valid; write_addr = read_addr; color_detected = det.
//   - If pix_valid=0: we=0 and color_detected=0; write_addr and history outputs hold.
//  Accumulate: det[c] with in-range x,y -> count[c]+1 (saturates at 2^CNT_W-1); min/max updated with <=/>=.
//   - Out-of-range pixel: history is still written back; not counted; bbox unaffected.
//  Frame edge (edge = vs_prev & ~VGA_VS, vs_prev registered every cycle):
//   - A pixel accepted in the edge cycle belongs to the closing frame.
//   - Latch = accumulator with that pixel folded in; accumulators reload to their cleared values in the same cycle.
//   - Outputs update on the edge+1 clock; frame_valid=1 for exactly that cycle.
//   - found[c] = latched count >= MIN_COUNT. found=0 -> that channel's bbox outputs are forced to 0.
//   - First edge after reset closes a partial frame: clears and sets armed, but no latch and no frame_valid.
//   - Results hold between edges; frame_valid stays 0 with no edge.
//  Reset mid-frame: all state discards immediately; the next edge only arms.
// STRUCTURE
//  Package color_detect_pkg: SCREEN_W=640, SCREEN_H=480, COORD_W=10, ADDR_W=19, and a popcount function.
//  Sub-module ch_bbox_accum (one per channel, generate loop): count/min/max accumulate, clear, latch, found gating.
//  The top holds the pixel path, the edge detect and the armed flag.
// TESTING
//  1. Reset then idle: all outputs 0; toggle VGA_VS once -> frame_valid stays 0 (arming edge only).
//  2. N_CH=3, thr=2, ch0 hist=0111, median=001 at (10,20) -> next cycle: color_detected=001, ch0 hist 1111, we=1, write_addr equals read_addr.
//  3. Ch1: 20 detects, box x=5..100, y=7..50, then VS edge -> count=20, found[1]=1, bbox 5/100/7/50, frame_valid one cycle.
//  4. Ch2: only 10 detects (< MIN_COUNT) -> found[2]=0, bbox outputs 0, count=10.
//  5. Pixel at x=700 detecting -> we=1 and history updated, but count unchanged; detect on the edge cycle -> included in the latched count.
//  6. Assert reset mid-frame after 30 detects -> outputs 0; next edge gives no frame_valid; following frame reports its own count only.

Source files
------------

// File: rtl/color_detect_pkg.sv
// Shared constants, bounding-box record and popcount helper for the
// multi-channel colour tracker.
package color_detect_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;
    localparam int ADDR_W   = 19;
    localparam int POP_W    = 8;

    typedef enum logic {
        ARM_IDLE   = 1'b0,
        ARM_ACTIVE = 1'b1
    } arm_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x_min;
        logic [COORD_W-1:0] x_max;
        logic [COORD_W-1:0] y_min;
        logic [COORD_W-1:0] y_max;
    } bbox_t;

    function automatic logic [3:0] popcount(input logic [POP_W-1:0] bits);
        logic [3:0] sum;
        sum = 4'd0;
        for (int i = 0; i < POP_W; i++) begin
            sum = sum + {3'd0, bits[i]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/color_track_multi_if.sv
// Pixel/history-RAM/frame-result bundle of the multi-channel colour tracker.
// The slave modport is the tracker's own view.
interface color_track_multi_if #(
    parameter int N_CH   = 3,
    parameter int HIST_D = 4,
    parameter int THR_W  = 3,
    parameter int CNT_W  = 19
);
    import color_detect_pkg::*;

    logic                     VGA_VS;
    logic                     pix_valid;
    logic [COORD_W-1:0]       read_x;
    logic [COORD_W-1:0]       read_y;
    logic [ADDR_W-1:0]        read_addr;
    logic [N_CH-1:0]          median_color;
    logic [N_CH*HIST_D-1:0]   color_history;
    logic [N_CH*THR_W-1:0]    threshold;

    logic [N_CH-1:0]          color_detected;
    logic [N_CH*HIST_D-1:0]   updated_color_history;
    logic                     we;
    logic [ADDR_W-1:0]        write_addr;
    logic                     frame_valid;
    logic [N_CH-1:0]          found;
    logic [N_CH*CNT_W-1:0]    color_count;
    logic [N_CH*COORD_W-1:0]  x_min;
    logic [N_CH*COORD_W-1:0]  x_max;
    logic [N_CH*COORD_W-1:0]  y_min;
    logic [N_CH*COORD_W-1:0]  y_max;

    modport master (
        output VGA_VS, pix_valid, read_x, read_y, read_addr,
               median_color, color_history, threshold,
        input  color_detected, updated_color_history, we, write_addr,
               frame_valid, found, color_count, x_min, x_max, y_min, y_max
    );

    modport slave (
        input  VGA_VS, pix_valid, read_x, read_y, read_addr,
               median_color, color_history, threshold,
        output color_detected, updated_color_history, we, write_addr,
               frame_valid, found, color_count, x_min, x_max, y_min, y_max
    );

endinterface

// File: rtl/ch_bbox_accum.sv
// One channel's per-frame pixel count and bounding box: accumulates hits,
// snapshots the closing frame on latch and reloads on clear.
module ch_bbox_accum
    import color_detect_pkg::*;
#(
    parameter int CNT_W     = 19,
    parameter int MIN_COUNT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hit,
    input  logic [COORD_W-1:0]  x,
    input  logic [COORD_W-1:0]  y,
    input  logic                clear,
    input  logic                latch,
    output logic [CNT_W-1:0]    count,
    output logic                found,
    output logic [COORD_W-1:0]  x_min,
    output logic [COORD_W-1:0]  x_max,
    output logic [COORD_W-1:0]  y_min,
    output logic [COORD_W-1:0]  y_max
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam bbox_t            BOX_CLEAR = '{
        x_min: COORD_W'(SCREEN_W - 1),
        x_max: {COORD_W{1'b0}},
        y_min: COORD_W'(SCREEN_H - 1),
        y_max: {COORD_W{1'b0}}
    };

    logic [CNT_W-1:0] acc_cnt_r;
    bbox_t            acc_box_r;
    logic [CNT_W-1:0] nxt_cnt_s;
    bbox_t            nxt_box_s;
    logic             nxt_found_s;

    logic [CNT_W-1:0] count_r;
    logic             found_r;
    bbox_t            box_r;

    // Fold this cycle's hit into the running accumulator; latch sees the result too.
    always_comb begin
        nxt_cnt_s = acc_cnt_r;
        nxt_box_s = acc_box_r;
        if (hit) begin
            nxt_cnt_s       = (acc_cnt_r != CNT_MAX) ? acc_cnt_r + CNT_W'(1) : acc_cnt_r;
            nxt_box_s.x_min = (x <= acc_box_r.x_min) ? x : acc_box_r.x_min;
            nxt_box_s.x_max = (x >= acc_box_r.x_max) ? x : acc_box_r.x_max;
            nxt_box_s.y_min = (y <= acc_box_r.y_min) ? y : acc_box_r.y_min;
            nxt_box_s.y_max = (y >= acc_box_r.y_max) ? y : acc_box_r.y_max;
        end else begin
            nxt_cnt_s = acc_cnt_r;
            nxt_box_s = acc_box_r;
        end
        nxt_found_s = (nxt_cnt_s >= CNT_W'(MIN_COUNT));
    end

    // Running accumulator, reloaded at every frame boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_cnt_r <= {CNT_W{1'b0}};
            acc_box_r <= BOX_CLEAR;
        end else if (clear) begin
            acc_cnt_r <= {CNT_W{1'b0}};
            acc_box_r <= BOX_CLEAR;
        end else begin
            acc_cnt_r <= nxt_cnt_s;
            acc_box_r <= nxt_box_s;
        end
    end

    // Frame results; a channel that was not found reports an all-zero box.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
            found_r <= 1'b0;
            box_r   <= '0;
        end else if (latch) begin
            count_r <= nxt_cnt_s;
            found_r <= nxt_found_s;
            box_r   <= nxt_found_s ? nxt_box_s : '0;
        end
    end

    assign count = count_r;
    assign found = found_r;
    assign x_min = box_r.x_min;
    assign x_max = box_r.x_max;
    assign y_min = box_r.y_min;
    assign y_max = box_r.y_max;

endmodule

// File: rtl/color_track_multi.sv
// N-channel temporal-history colour detector with per-frame count and
// bounding box per channel, latched at each VGA_VS falling edge.
module color_track_multi
    import color_detect_pkg::*;
#(
    parameter int N_CH      = 3,
    parameter int HIST_D    = 4,
    parameter int THR_W     = 3,
    parameter int CNT_W     = 19,
    parameter int MIN_COUNT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    color_track_multi_if.slave   bus
);

    logic [N_CH-1:0]         det_s;
    logic [N_CH*HIST_D-1:0]  upd_hist_s;
    logic                    in_range_s;
    logic                    edge_s;
    logic                    latch_s;

    logic [N_CH-1:0]         det_r;
    logic [N_CH*HIST_D-1:0]  hist_r;
    logic                    we_r;
    logic [ADDR_W-1:0]       waddr_r;
    logic                    vs_prev_r;
    arm_state_t              arm_r;
    logic                    frame_valid_r;

    logic [CNT_W-1:0]        cnt_s   [N_CH];
    logic [N_CH-1:0]         found_s;
    logic [COORD_W-1:0]      xmin_s  [N_CH];
    logic [COORD_W-1:0]      xmax_s  [N_CH];
    logic [COORD_W-1:0]      ymin_s  [N_CH];
    logic [COORD_W-1:0]      ymax_s  [N_CH];

    // Per-channel detect and history shift; the raw median bit is shifted in, not the detect.
    always_comb begin
        det_s      = {N_CH{1'b0}};
        upd_hist_s = {(N_CH*HIST_D){1'b0}};
        for (int c = 0; c < N_CH; c++) begin
            det_s[c] = bus.pix_valid & bus.median_color[c] &
                       ({4'd0, popcount(POP_W'(bus.color_history[c*HIST_D +: HIST_D]))} >
                        8'(bus.threshold[c*THR_W +: THR_W]));
            upd_hist_s[c*HIST_D +: HIST_D] =
                {bus.color_history[c*HIST_D +: HIST_D-1], bus.median_color[c]};
        end
    end

    assign in_range_s = (bus.read_x < COORD_W'(SCREEN_W)) && (bus.read_y < COORD_W'(SCREEN_H));
    assign edge_s     = vs_prev_r & ~bus.VGA_VS;
    assign latch_s    = edge_s & (arm_r == ARM_ACTIVE);

    // Registered pixel path; address and history hold while no pixel is offered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            det_r   <= {N_CH{1'b0}};
            hist_r  <= {(N_CH*HIST_D){1'b0}};
            we_r    <= 1'b0;
            waddr_r <= {ADDR_W{1'b0}};
        end else begin
            det_r <= det_s;
            we_r  <= bus.pix_valid;
            if (bus.pix_valid) begin
                hist_r  <= upd_hist_s;
                waddr_r <= bus.read_addr;
            end
        end
    end

    // Frame boundary tracking; the first edge after reset only arms.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_prev_r     <= 1'b0;
            arm_r         <= ARM_IDLE;
            frame_valid_r <= 1'b0;
        end else begin
            vs_prev_r     <= bus.VGA_VS;
            frame_valid_r <= latch_s;
            case (arm_r)
                ARM_IDLE:   arm_r <= edge_s ? ARM_ACTIVE : ARM_IDLE;
                ARM_ACTIVE: arm_r <= ARM_ACTIVE;
                default:    arm_r <= ARM_IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        ch_bbox_accum #(
            .CNT_W     (CNT_W),
            .MIN_COUNT (MIN_COUNT)
        ) u_accum (
            .clk   (clk),
            .reset (reset),
            .hit   (det_s[c] & in_range_s),
            .x     (bus.read_x),
            .y     (bus.read_y),
            .clear (edge_s),
            .latch (latch_s),
            .count (cnt_s[c]),
            .found (found_s[c]),
            .x_min (xmin_s[c]),
            .x_max (xmax_s[c]),
            .y_min (ymin_s[c]),
            .y_max (ymax_s[c])
        );
    end

    // Flatten per-channel results onto the packed output buses.
    always_comb begin
        bus.color_count = {(N_CH*CNT_W){1'b0}};
        bus.x_min       = {(N_CH*COORD_W){1'b0}};
        bus.x_max       = {(N_CH*COORD_W){1'b0}};
        bus.y_min       = {(N_CH*COORD_W){1'b0}};
        bus.y_max       = {(N_CH*COORD_W){1'b0}};
        for (int c = 0; c < N_CH; c++) begin
            bus.color_count[c*CNT_W +: CNT_W] = cnt_s[c];
            bus.x_min[c*COORD_W +: COORD_W]   = xmin_s[c];
            bus.x_max[c*COORD_W +: COORD_W]   = xmax_s[c];
            bus.y_min[c*COORD_W +: COORD_W]   = ymin_s[c];
            bus.y_max[c*COORD_W +: COORD_W]   = ymax_s[c];
        end
    end

    assign bus.color_detected        = det_r;
    assign bus.updated_color_history = hist_r;
    assign bus.we                    = we_r;
    assign bus.write_addr            = waddr_r;
    assign bus.frame_valid           = frame_valid_r;
    assign bus.found                 = found_s;

endmodule
